// File: rtl/button_rotate_controller.sv
// Pushbutton front end for the rotate datapath: sync + debounce + edge detect per
// button, then a two-state FSM that rotates or loads the 16-bit LED register.
module button_rotate_controller #(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [15:0] INIT_VALUE      = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BTNR,
    input  logic        BTNL,
    input  logic        BTNC,
    input  logic        BTNU,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        busy,
    output logic [7:0]  rot_count
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] STEP = 1'b1;

    // Bit order in all per-button vectors: {U, C, L, R}
    logic [3:0]    raw;
    logic [3:0]    sync1, sync2, db, db_q;
    logic [CW-1:0] cnt [4];
    logic [3:0]    pulse;

    assign raw = {BTNU, BTNC, BTNL, BTNR};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            // A level is accepted only after it has disagreed with db for DEBOUNCE_CYCLES edges
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        db[i]  <= ~db[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign pulse = db & ~db_q;

    logic       pr, pl, pu, c_lvl;
    assign pr    = pulse[0];
    assign pl    = pulse[1];
    assign pu    = pulse[3];
    assign c_lvl = db[2];

    function automatic logic [15:0] rot1(input logic [15:0] v, input logic left);
        rot1 = left ? {v[14:0], v[15]} : {v[0], v[15:1]};
    endfunction

    logic [0:0] state;
    logic       dir_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= INIT_VALUE;
            state     <= IDLE;
            dir_left  <= 1'b0;
            rot_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pu) begin
                        led <= sw;
                    end else if (pr ^ pl) begin
                        led      <= rot1(led, pl);
                        dir_left <= pl;
                        // Two-bit steps count only once the second bit lands
                        if (c_lvl) state     <= STEP;
                        else       rot_count <= rot_count + 8'd1;
                    end
                end
                STEP: begin
                    led       <= rot1(led, dir_left);
                    rot_count <= rot_count + 8'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == STEP);

endmodule

// File: tb/tb_button_rotate_controller.sv
// Directed bench for button_rotate_controller with DEBOUNCE_CYCLES=4
// (press-to-led latency is 7 edges).
module tb_button_rotate_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        BTNR, BTNL, BTNC, BTNU;
    logic [15:0] sw;
    logic [15:0] led;
    logic        busy;
    logic [7:0]  rot_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_led;

    button_rotate_controller #(.DEBOUNCE_CYCLES(4), .INIT_VALUE(16'h0001)) dut (
        .clk(clk), .rst(rst),
        .BTNR(BTNR), .BTNL(BTNL), .BTNC(BTNC), .BTNU(BTNU),
        .sw(sw), .led(led), .busy(busy), .rot_count(rot_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver: advance n rising edges, land 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] v);
        sw   = v;
        BTNU = 1'b1;
        tick(8);
        BTNU = 1'b0;
        tick(8);
    endtask

    initial begin
        rst = 1'b1; BTNR = 0; BTNL = 0; BTNC = 0; BTNU = 0; sw = '0;
        tick(3);
        rst = 1'b0;
        check("reset_led",   led, 16'h0001);
        check("reset_busy",  {15'd0, busy}, 16'd0);
        check("reset_count", {8'd0, rot_count}, 16'd0);

        // Held BTNR: change lands exactly 7 edges after the press, once
        BTNR = 1'b1;
        tick(6);
        check("r_before_latency", led, 16'h0001);
        tick(1);
        check("r_at_latency", led, 16'h8000);
        check("r_count", {8'd0, rot_count}, 16'd1);
        tick(3);
        check("r_held_no_repeat", led, 16'h8000);
        BTNR = 1'b0;
        tick(8);
        check("r_release_no_cmd", led, 16'h8000);

        // 3-cycle glitch on BTNL is filtered out
        BTNL = 1'b1;
        tick(3);
        BTNL = 1'b0;
        tick(8);
        check("glitch_led",   led, 16'h8000);
        check("glitch_count", {8'd0, rot_count}, 16'd1);

        // Load, then two-bit left rotate with BTNC held
        load(16'hA5C3);
        check("load_led",   led, 16'hA5C3);
        check("load_count", {8'd0, rot_count}, 16'd1);
        BTNC = 1'b1;
        tick(8);
        BTNL = 1'b1;
        tick(6);
        check("l2_pre_led",  led, 16'hA5C3);
        check("l2_pre_busy", {15'd0, busy}, 16'd0);
        tick(1);
        check("l2_first_led",   led, 16'h4B87);
        check("l2_first_busy",  {15'd0, busy}, 16'd1);
        check("l2_first_count", {8'd0, rot_count}, 16'd1);
        tick(1);
        check("l2_second_led",   led, 16'h970E);
        check("l2_second_busy",  {15'd0, busy}, 16'd0);
        check("l2_second_count", {8'd0, rot_count}, 16'd2);
        BTNL = 1'b0; BTNC = 1'b0;
        tick(8);

        // Simultaneous R and L presses cancel
        load(16'h0001);
        BTNR = 1'b1; BTNL = 1'b1;
        tick(8);
        check("rl_led",   led, 16'h0001);
        check("rl_count", {8'd0, rot_count}, 16'd2);
        BTNR = 1'b0; BTNL = 1'b0;
        tick(8);

        // Reset during the STEP cycle discards the second bit
        load(16'h0003);
        BTNC = 1'b1;
        tick(8);
        BTNR = 1'b1;
        tick(7);
        check("rst_step_first_led", led, 16'h8001);
        check("rst_step_busy",      {15'd0, busy}, 16'd1);
        rst = 1'b1; BTNR = 1'b0; BTNC = 1'b0;
        tick(1);
        check("rst_step_led",   led, 16'h0001);
        check("rst_step_busy0", {15'd0, busy}, 16'd0);
        check("rst_step_count", {8'd0, rot_count}, 16'd0);
        rst = 1'b0;
        tick(8);
        check("rst_step_quiet", led, 16'h0001);

        // BTNR pulse landing in STEP is dropped
        BTNC = 1'b1;
        tick(8);
        BTNL = 1'b1;
        tick(1);
        BTNR = 1'b1;
        tick(6);
        check("drop_first_led", led, 16'h0002);
        check("drop_busy",      {15'd0, busy}, 16'd1);
        tick(1);
        check("drop_second_led", led, 16'h0004);
        check("drop_count",      {8'd0, rot_count}, 16'd1);
        tick(8);
        check("drop_no_r_led",   led, 16'h0004);
        check("drop_no_r_count", {8'd0, rot_count}, 16'd1);
        BTNL = 1'b0; BTNR = 1'b0; BTNC = 1'b0;
        tick(8);

        // 255 more single rotates: count wraps to 0
        model_led = 16'h0004;
        for (int i = 0; i < 255; i++) begin
            model_led = {model_led[0], model_led[15:1]};
            exp_q.push_back(model_led);
            BTNR = 1'b1;
            tick(7);
            check("wrap_led", led, exp_q.pop_front());
            BTNR = 1'b0;
            tick(7);
        end
        check("wrap_final_led",   led, 16'h0008);
        check("wrap_final_count", {8'd0, rot_count}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_rotate_controller.md
Name: button_rotate_controller

Overview:
Sequential front end for the board's rotate datapath. Conditions raw pushbuttons (synchronize, debounce, rising-edge detect) and turns each press into rotate or load commands on a held 16-bit register driven to the LEDs. BTNC is a step-size modifier. Multi-bit rotations execute one bit per clock under a small FSM.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); minimum 2
INIT_VALUE, 16'h0001, register value after reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
BTNR  input  1  raw button: rotate right
BTNL  input  1  raw button: rotate left
BTNC  input  1  raw button: modifier, held level selects 2-bit step
BTNU  input  1  raw button: load sw into register
sw  input  16  load data
led  output  16  current register value
busy  output  1  high while a multi-step rotation is in progress
rot_count  output  8  number of completed rotate commands, wraps 255->0

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clk edge. Sets led=INIT_VALUE, busy=0, rot_count=0, FSM=IDLE. Clears synchronizers, debounce counters and debounced levels to 0. Reset wins over every other event, including mid-rotation: a pending second step is discarded.
- Per button (R, L, C, U): 2-flop synchronizer, then debouncer.
  - The debounce counter increments while the synchronized level differs from the debounced level. It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Edge detect: a one-cycle pulse on the debounced 0->1 transition for R, L and U. C is used as a level only.
- Command decode happens in IDLE on the pulse cycle, with priority U > R > L:
  - U pulse: led<=sw at that edge; rot_count unchanged.
  - R pulse alone: rotate right by 1, led<={led[0],led[15:1]}.
  - L pulse alone: rotate left by 1, led<={led[14:0],led[15]}.
  - R and L pulses in the same cycle: no rotation, no count.
  - If the debounced C level is 1 on the R/L pulse cycle, the step is 2: the first bit is applied at that edge, the FSM goes to STEP and busy=1. The second bit is applied at the next edge, then the FSM returns to IDLE and busy=0.
- FSM states:
  - IDLE: all commands are accepted.
  - STEP: exactly one cycle long, applies the second bit in the stored direction. R, L and U pulses arriving in STEP are dropped, not queued.
- rot_count increments by 1 per accepted rotate command, regardless of step size, at the edge the command completes. That is the first edge for step 1 and the STEP edge for step 2. It wraps modulo 256.
- Latency from a raw press to the led change is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. There is no further rotation while the button is held, and release produces no command.
- Outputs are registered; no combinational path exists from inputs to outputs.

Test Plan (DEBOUNCE_CYCLES=4 in sim):
- Reset, then hold BTNR high for 10 cycles -> led 16'h0001 -> 16'h8000 exactly 7 cycles after the press; rot_count=1; only one change while held.
- Pulse BTNL high for 3 cycles only -> led unchanged, rot_count unchanged.
- sw=16'hA5C3, press BTNU -> led=16'hA5C3, rot_count unchanged. Then hold BTNC and press BTNL -> busy high for 1 cycle, led=16'h970E after the second step, rot_count+1.
- led=16'h0001, BTNR and BTNL pressed on the same cycle -> led stays 16'h0001, no count.
- Start a BTNC+BTNR double step from 16'h0003 and assert rst in the STEP cycle -> led=16'h0001, busy=0, rot_count=0 after that edge.
- Issue 256 single rotates -> rot_count wraps to 0. A BTNR press that debounces during STEP is ignored.
